// File: rtl/seg7_multi_display.sv
// seg7_multi_display
//   Multi-digit seven-segment driver. A WIDTH-bit binary value becomes DIGITS
//   digits, shown either as hex nibbles or as decimal digits. Decimal digits come
//   from a sequential double-dabble, one iteration per clock. Further features:
//   leading-zero blanking, overflow indication and a load/busy/done handshake.
//
// Ports
//   clock_i     system clock, all logic on the rising edge
//   reset_i     synchronous, active-high reset
//   load_i      start a conversion of value_i (only honoured while idle)
//   value_i     binary value to display
//   mode_i      0 = hex, 1 = decimal; latched together with load_i
//   blank_i     1 = blank leading zeros; latched together with load_i
//   busy_o      conversion in progress
//   done_o      one-cycle pulse in the cycle hex_o takes its new value
//   overflow_o  value does not fit in DIGITS digits; held until the next done_o
//   hex_o       active-low segments, digit i = hex_o[7*i+6:7*i] = {a,b,c,d,e,f,g}

module seg7_multi_display #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int CNTW   = 5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      value_i,
  input  logic                  mode_i,
  input  logic                  blank_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [7*DIGITS-1:0]   hex_o
);

  // One spare BCD digit on top exists only to detect decimal overflow.
  localparam int BCDW = 4*DIGITS + 4;
  localparam int EXTW = WIDTH + 4*DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    val_q, val_d;
  logic                mode_q, mode_d;
  logic                blank_q, blank_d;
  logic [BCDW-1:0]     bcd_q, bcd_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                sticky_q, sticky_d;
  logic [7*DIGITS-1:0] hex_q, hex_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [BCDW-1:0]     bcdAdj;
  logic [EXTW-1:0]     valExt;
  logic [4*DIGITS-1:0] digitsVal;
  logic [7*DIGITS-1:0] hexNext;
  logic                ovfNext;
  logic                seen;
  logic [3:0]          nib;

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'h0: segOf = 7'b0000001;
      4'h1: segOf = 7'b1001111;
      4'h2: segOf = 7'b0010010;
      4'h3: segOf = 7'b0000110;
      4'h4: segOf = 7'b1001100;
      4'h5: segOf = 7'b0100100;
      4'h6: segOf = 7'b0100000;
      4'h7: segOf = 7'b0001111;
      4'h8: segOf = 7'b0000000;
      4'h9: segOf = 7'b0000100;
      4'hA: segOf = 7'b0001000;
      4'hB: segOf = 7'b1100000;
      4'hC: segOf = 7'b0110001;
      4'hD: segOf = 7'b1000010;
      4'hE: segOf = 7'b0110000;
      default: segOf = 7'b0111000;
    endcase
  endfunction

  // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i <= DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Zero-extend the latched value so that nibbles beyond WIDTH read as 0 in hex mode.
  // The bits above the displayed nibbles signal hex overflow.
  assign valExt = EXTW'(val_q);

  // Digit selection, overflow detection and blanking for the UPDATE cycle.
  // The scan runs from the top digit down. Blanking stops at the first nonzero
  // digit, and it never applies to digit 0.
  always_comb begin
    digitsVal = mode_q ? bcd_q[4*DIGITS-1:0] : valExt[4*DIGITS-1:0];
    ovfNext   = mode_q ? ((|bcd_q[BCDW-1:4*DIGITS]) | sticky_q)
                       : (|valExt[EXTW-1:4*DIGITS]);
    hexNext   = '1;
    seen      = 1'b0;
    nib       = 4'd0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      nib  = digitsVal[4*i +: 4];
      seen = seen | (nib != 4'd0);
      if (mode_q && ovfNext) begin
        hexNext[7*i +: 7] = 7'b1111110;
      end else if (blank_q && !seen && (i != 0)) begin
        hexNext[7*i +: 7] = 7'b1111111;
      end else begin
        hexNext[7*i +: 7] = segOf(nib);
      end
    end
  end

  // Next-state logic. The working value register also serves as the shift source.
  // A bit pushed out of the top BCD digit means the number was too large even for
  // the spare digit, so it is remembered as sticky overflow.
  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    mode_d   = mode_q;
    blank_d  = blank_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    hex_d    = hex_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_i) begin
          val_d    = value_i;
          mode_d   = mode_i;
          blank_d  = blank_i;
          bcd_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = mode_i ? SHIFT : UPDATE;
        end
      end
      SHIFT: begin
        bcd_d    = {bcdAdj[BCDW-2:0], val_q[WIDTH-1]};
        val_d    = {val_q[WIDTH-2:0], 1'b0};
        sticky_d = sticky_q | bcdAdj[BCDW-1];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNTW'(WIDTH-1)) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        hex_d   = hexNext;
        ovf_d   = ovfNext;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset wins over load and aborts a conversion without a done pulse.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      val_q    <= '0;
      mode_q   <= 1'b0;
      blank_q  <= 1'b0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      hex_q    <= '1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      mode_q   <= mode_d;
      blank_q  <= blank_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      hex_q    <= hex_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
  assign hex_o      = hex_q;

endmodule

// File: tb/tb_seg7_multi_display.sv
// tb_seg7_multi_display
//   Directed bench for seg7_multi_display. The bench drives three instances from
//   the same inputs: DIGITS = 3, 4 and 5, all with WIDTH = 16. Each vector names
//   the instance it checks. The bench also checks expected segment patterns,
//   overflow, done latency, busy and the one-cycle done pulse. Hand-written
//   sequences cover load-while-busy and reset during a conversion.

module tb_seg7_multi_display;

  localparam logic [6:0] D0 = 7'b0000001, D1 = 7'b1001111, D2 = 7'b0010010,
                         D3 = 7'b0000110, D4 = 7'b1001100, D5 = 7'b0100100,
                         D6 = 7'b0100000, D9 = 7'b0000100, DA = 7'b0001000,
                         Db = 7'b1100000, DE = 7'b0110000, DF = 7'b0111000,
                         BL = 7'b1111111, DASH = 7'b1111110;

  typedef struct {
    int          sel;
    logic        mode;
    logic        blank;
    logic [15:0] value;
    logic [34:0] expHex;
    logic        expOvf;
    string       name;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load  = 1'b0;
  logic [15:0] value = '0;
  logic        mode  = 1'b0;
  logic        blank = 1'b0;

  logic        busy3, busy4, busy5, done3, done4, done5, ovf3, ovf4, ovf5;
  logic [20:0] hex3;
  logic [27:0] hex4;
  logic [34:0] hex5;

  int          curSel = 5;
  logic        selBusy, selDone, selOvf;
  logic [34:0] selHex;

  int vecCount = 0;
  int errCount = 0;

  vec_t vecs[18];

  seg7_multi_display #(.WIDTH(16), .DIGITS(3), .CNTW(5)) dut3 (
    .clock_i(clock), .reset_i(reset), .load_i(load), .value_i(value),
    .mode_i(mode), .blank_i(blank), .busy_o(busy3), .done_o(done3),
    .overflow_o(ovf3), .hex_o(hex3));

  seg7_multi_display #(.WIDTH(16), .DIGITS(4), .CNTW(5)) dut4 (
    .clock_i(clock), .reset_i(reset), .load_i(load), .value_i(value),
    .mode_i(mode), .blank_i(blank), .busy_o(busy4), .done_o(done4),
    .overflow_o(ovf4), .hex_o(hex4));

  seg7_multi_display #(.WIDTH(16), .DIGITS(5), .CNTW(5)) dut5 (
    .clock_i(clock), .reset_i(reset), .load_i(load), .value_i(value),
    .mode_i(mode), .blank_i(blank), .busy_o(busy5), .done_o(done5),
    .overflow_o(ovf5), .hex_o(hex5));

  always #5 clock = ~clock;

  // Route the outputs of whichever instance the current vector targets.
  always_comb begin
    case (curSel)
      3: begin selBusy = busy3; selDone = done3; selOvf = ovf3; selHex = 35'(hex3); end
      4: begin selBusy = busy4; selDone = done4; selOvf = ovf4; selHex = 35'(hex4); end
      default: begin selBusy = busy5; selDone = done5; selOvf = ovf5; selHex = hex5; end
    endcase
  end

  task automatic checkOutput(input string name, input logic [34:0] act, input logic [34:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Load one vector. Inputs are scrambled once load drops. The task then waits a
  // bounded number of cycles for done and checks latency, busy, result and pulse width.
  task automatic applyStimulus(input vec_t v);
    int   got;
    logic busyGap;
    int   expLat;
    got     = 0;
    busyGap = 1'b0;
    expLat  = v.mode ? 18 : 2;
    curSel  = v.sel;
    @(negedge clock);
    value = v.value;
    mode  = v.mode;
    blank = v.blank;
    load  = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) begin
        load  = 1'b0;
        value = ~v.value;
        mode  = ~v.mode;
        blank = ~v.blank;
      end
      if (selDone) begin
        got = n;
        break;
      end
      if (!selBusy) busyGap = 1'b1;
    end
    checkOutput({v.name, " latency"}, 35'(got), 35'(expLat));
    checkOutput({v.name, " busy"}, 35'(busyGap), 35'(0));
    checkOutput({v.name, " hex"}, selHex, v.expHex);
    checkOutput({v.name, " ovf"}, 35'(selOvf), 35'(v.expOvf));
    @(posedge clock);
    #1;
    checkOutput({v.name, " donePulse"}, 35'(selDone), 35'(0));
  endtask

  initial begin
    int doneCount;
    int firstDone;

    vecs[0]  = '{4, 1'b0, 1'b0, 16'hBEEF, 35'({Db, DE, DE, DF}), 1'b0, "hexBEEF4"};
    vecs[1]  = '{5, 1'b1, 1'b0, 16'd12345, {D1, D2, D3, D4, D5}, 1'b0, "dec12345"};
    vecs[2]  = '{5, 1'b1, 1'b1, 16'd42, {BL, BL, BL, D4, D2}, 1'b0, "dec42blank"};
    vecs[3]  = '{5, 1'b1, 1'b1, 16'd0, {BL, BL, BL, BL, D0}, 1'b0, "dec0blank"};
    vecs[4]  = '{4, 1'b1, 1'b0, 16'd65535, 35'({DASH, DASH, DASH, DASH}), 1'b1, "dec65535ovf"};
    vecs[5]  = '{4, 1'b1, 1'b0, 16'd9999, 35'({D9, D9, D9, D9}), 1'b0, "dec9999"};
    vecs[6]  = '{4, 1'b1, 1'b1, 16'd65535, 35'({DASH, DASH, DASH, DASH}), 1'b1, "ovfBlankIgn"};
    vecs[7]  = '{5, 1'b1, 1'b0, 16'd65535, {D6, D5, D5, D3, D5}, 1'b0, "decMax5"};
    vecs[8]  = '{5, 1'b0, 1'b1, 16'h00A0, {BL, BL, BL, DA, D0}, 1'b0, "hexA0blank"};
    vecs[9]  = '{5, 1'b0, 1'b0, 16'hBEEF, {D0, Db, DE, DE, DF}, 1'b0, "hexBEEF5"};
    vecs[10] = '{5, 1'b1, 1'b0, 16'd100, {D0, D0, D1, D0, D0}, 1'b0, "dec100"};
    vecs[11] = '{5, 1'b1, 1'b1, 16'd10000, {D1, D0, D0, D0, D0}, 1'b0, "dec10000blank"};
    vecs[12] = '{5, 1'b0, 1'b1, 16'h0000, {BL, BL, BL, BL, D0}, 1'b0, "hex0blank"};
    vecs[13] = '{4, 1'b1, 1'b0, 16'd10000, 35'({DASH, DASH, DASH, DASH}), 1'b1, "dec10000ovf4"};
    vecs[14] = '{5, 1'b0, 1'b1, 16'h1234, {BL, D1, D2, D3, D4}, 1'b0, "hex1234blank"};
    vecs[15] = '{3, 1'b0, 1'b0, 16'h1234, 35'({D2, D3, D4}), 1'b1, "hexOvf3"};
    vecs[16] = '{3, 1'b0, 1'b0, 16'h0234, 35'({D2, D3, D4}), 1'b0, "hexNoOvf3"};
    vecs[17] = '{3, 1'b1, 1'b0, 16'd999, 35'({D9, D9, D9}), 1'b0, "dec999d3"};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    curSel = 5;
    checkOutput("resetBusy", 35'(selBusy), 35'(0));
    checkOutput("resetDone", 35'(selDone), 35'(0));
    checkOutput("resetOvf", 35'(selOvf), 35'(0));
    checkOutput("resetHex", selHex, '1);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
    end

    // Load pulse during a decimal conversion of 100 must be ignored.
    curSel    = 5;
    doneCount = 0;
    firstDone = 0;
    @(negedge clock);
    value = 16'd100;
    mode  = 1'b1;
    blank = 1'b0;
    load  = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) load = 1'b0;
      if (n == 2) begin
        load  = 1'b1;
        value = 16'd5;
        mode  = 1'b0;
        blank = 1'b1;
      end
      if (n == 3) load = 1'b0;
      if (selDone) begin
        doneCount++;
        if (firstDone == 0) firstDone = n;
      end
    end
    checkOutput("ignLoadLatency", 35'(firstDone), 35'(18));
    checkOutput("ignLoadDoneCnt", 35'(doneCount), 35'(1));
    checkOutput("ignLoadHex", selHex, {D0, D0, D1, D0, D0});

    // Reset mid-conversion, with load high in the same cycle.
    @(negedge clock);
    value = 16'd12345;
    mode  = 1'b1;
    blank = 1'b0;
    load  = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) load = 1'b0;
      if (n == 4) begin
        reset = 1'b1;
        load  = 1'b1;
      end
    end
    checkOutput("midResetBusy", 35'(selBusy), 35'(0));
    checkOutput("midResetHex", selHex, '1);
    checkOutput("midResetDone", 35'(selDone), 35'(0));
    reset = 1'b0;
    load  = 1'b0;
    doneCount = 0;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clock);
      #1;
      if (selDone) doneCount++;
    end
    checkOutput("midResetNoDone", 35'(doneCount), 35'(0));
    applyStimulus(vecs[2]);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
